// File: rtl/dpll_pkg.sv
// Shared types for the DPLL lock controller: state and NCO adjust encodings.
// Also holds the default counter width and the adjust-select helper.
package dpll_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_TRACK   = 2'd2,
      ST_LOCKED  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ADJ_ZERO = 2'b00,
      ADJ_INC  = 2'b01,
      ADJ_DEC  = 2'b11
   } adj_e;

   function automatic adj_e adj_of(input logic neg, input logic zero);
      adj_e a;
      unique case (1'b1)
         zero:    a = ADJ_ZERO;
         neg:     a = ADJ_DEC;
         default: a = ADJ_INC;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/dpll_lock_ctrl_if.sv
// Control/status bundle between the DPLL loop controller and its neighbours.
// master drives enable and reference pulse; slave is the controller.
interface dpll_lock_ctrl_if
   import dpll_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);

   logic             en;
   logic             ref_pulse;
   logic [CNT_W-1:0] div_out;
   logic [CNT_W-1:0] phase_err;
   logic             out_clk;
   logic             out_pulse;
   logic             locked;
   logic [1:0]       state;

   modport master (
      output en,
      output ref_pulse,
      input  div_out,
      input  phase_err,
      input  out_clk,
      input  out_pulse,
      input  locked,
      input  state
   );

   modport slave (
      input  en,
      input  ref_pulse,
      output div_out,
      output phase_err,
      output out_clk,
      output out_pulse,
      output locked,
      output state
   );

endinterface

// File: rtl/dpll_nco.sv
// Counter-based local oscillator: phase counter with +/-1 cycle stretch.
// Decodes the recovered clock and the phase-zero pulse.
module dpll_nco
   import dpll_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_50K,
   input  logic             rst_n,
   input  logic             run,
   input  logic             hold,
   input  logic             sync,
   input  logic [CNT_W-1:0] div,
   input  adj_e             adj,
   output logic [CNT_W-1:0] phase_cnt,
   output logic             wrap,
   output logic             out_clk,
   output logic             out_pulse
);

   logic [CNT_W-1:0] phase_q;
   logic [CNT_W-1:0] phase_d;
   logic [CNT_W:0]   lim;

   always_comb begin
      lim = {1'b0, div} - (CNT_W+1)'(1);
      unique case (adj)
         ADJ_INC: lim = {1'b0, div};
         ADJ_DEC: lim = {1'b0, div} - (CNT_W+1)'(2);
         default: lim = {1'b0, div} - (CNT_W+1)'(1);
      endcase
   end

   // >= rather than == so a late shortening never lets the count run past
   assign wrap = run && ({1'b0, phase_q} >= lim);

   always_comb begin
      phase_d = phase_q + CNT_W'(1);
      if (sync) begin
         phase_d = CNT_W'(1);
      end else if (hold || wrap) begin
         phase_d = '0;
      end
   end

   always_ff @(posedge clk_50K or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase_cnt = phase_q;
   assign out_clk   = run && (phase_q < (div >> 1));
   assign out_pulse = run && (phase_q == '0);

endmodule

// File: rtl/dpll_lock_ctrl.sv
// DPLL loop controller: measures the reference period, steers the NCO
// phase by +/-1 cycle and reports lock, phase error and divider.
module dpll_lock_ctrl
   import dpll_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DIV_MIN  = 4,
   parameter int DIV_MAX  = 4096,
   parameter int LOCK_TOL = 1,
   parameter int LOCK_CNT = 8
) (
   input logic             clk_50K,
   input logic             rst_n,
   dpll_lock_ctrl_if.slave bus
);

   localparam int LCW = $clog2(LOCK_CNT + 1);
   localparam logic signed [CNT_W-1:0] TOL_S = CNT_W'(LOCK_TOL);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [LCW-1:0]   lock_q, lock_d;
   logic             locked_q, locked_d;
   adj_e             adj_q, adj_d;

   logic                    pulse;
   logic                    run;
   logic                    run_d;
   logic                    sync;
   logic                    wrap;
   logic                    in_rng;
   logic                    in_tol;
   logic                    loss;
   logic                    meas_to;
   logic [CNT_W-1:0]        phase_cnt;
   logic [CNT_W-1:0]        e;
   logic signed [CNT_W-1:0] e_s;
   logic [LCW-1:0]          lock_inc;
   logic [CNT_W-1:0]        div_step;

   assign pulse   = bus.en && bus.ref_pulse;
   assign run     = (state_q == ST_TRACK) || (state_q == ST_LOCKED);
   assign run_d   = (state_d == ST_TRACK) || (state_d == ST_LOCKED);
   assign in_rng  = (per_q >= CNT_W'(DIV_MIN)) && (per_q <= CNT_W'(DIV_MAX));
   assign meas_to = per_q > CNT_W'(DIV_MAX);
   assign loss    = {1'b0, per_q} >= {div_q, 1'b0};

   // early half of the NCO cycle reads as late (+), second half as early (-)
   assign e      = (phase_cnt < (div_q >> 1)) ? phase_cnt : phase_cnt - div_q;
   assign e_s    = signed'(e);
   assign in_tol = (e_s <= TOL_S) && (e_s >= -TOL_S);

   assign lock_inc = (lock_q == '1) ? lock_q : lock_q + LCW'(1);

   always_comb begin
      div_step = div_q;
      if (per_q > div_q) begin
         div_step = div_q + CNT_W'(1);
      end else if (per_q < div_q) begin
         div_step = div_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_50K or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!bus.en) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.ref_pulse) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
               if (bus.ref_pulse) begin
                  if (in_rng) state_d = ST_TRACK;
               end else if (meas_to) begin
                  state_d = ST_IDLE;
               end
            end
            ST_TRACK: begin
               if (bus.ref_pulse) begin
                  if (in_tol && (lock_inc == LCW'(LOCK_CNT)))
                     state_d = ST_LOCKED;
               end else if (loss) begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOCKED: begin
               if (bus.ref_pulse) begin
                  if (!in_tol) state_d = ST_TRACK;
               end else if (loss) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      div_d  = div_q;
      err_d  = err_q;
      lock_d = lock_q;
      adj_d  = adj_q;
      sync   = 1'b0;
      if (wrap) adj_d = ADJ_ZERO;
      if (pulse) begin
         unique case (state_q)
            ST_MEASURE: begin
               if (in_rng) begin
                  div_d  = per_q;
                  lock_d = '0;
                  adj_d  = ADJ_ZERO;
                  sync   = 1'b1;
               end
            end
            ST_TRACK, ST_LOCKED: begin
               err_d  = e;
               adj_d  = adj_of(e_s < 0, e == '0);
               lock_d = in_tol ? lock_inc : '0;
               // an out-of-tolerance hit while locked is a phase step,
               // so it must not also drag the locked frequency
               if (in_rng) begin
                  if (state_q == ST_TRACK) div_d = per_q;
                  else if (in_tol)         div_d = div_step;
               end
            end
            default: ;
         endcase
      end
      if (!run_d) adj_d = ADJ_ZERO;
      locked_d = (state_d == ST_LOCKED);
      per_d    = (per_q == '1) ? per_q : per_q + CNT_W'(1);
      if (bus.ref_pulse) per_d = CNT_W'(1);
   end

   always_ff @(posedge clk_50K or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         err_q    <= '0;
         per_q    <= '0;
         lock_q   <= '0;
         locked_q <= 1'b0;
         adj_q    <= ADJ_ZERO;
      end else begin
         div_q    <= div_d;
         err_q    <= err_d;
         per_q    <= per_d;
         lock_q   <= lock_d;
         locked_q <= locked_d;
         adj_q    <= adj_d;
      end
   end

   dpll_nco #(
      .CNT_W(CNT_W)
   ) u_nco (
      .clk_50K  (clk_50K),
      .rst_n    (rst_n),
      .run      (run),
      .hold     (!run_d),
      .sync     (sync),
      .div      (div_q),
      .adj      (adj_q),
      .phase_cnt(phase_cnt),
      .wrap     (wrap),
      .out_clk  (bus.out_clk),
      .out_pulse(bus.out_pulse)
   );

   assign bus.state     = state_q;
   assign bus.div_out   = div_q;
   assign bus.phase_err = err_q;
   assign bus.locked    = locked_q;

endmodule
